// File: rtl/text_serializer.sv
// Frames reader bytes (preamble + data, optional even parity) into a paced serial bitstream.
// Build option: define TEXT_SERIALIZER_PARITY_EN to append an even-parity bit after each data byte.
module text_serializer #(
    parameter int unsigned NUM_BYTES  = 10,
    parameter int unsigned BIT_CYCLES = 4,
    parameter logic [7:0]  PREAMBLE   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       byte_req,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       busy,
    output logic       done
);

`ifdef TEXT_SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, PRE, DATA, DONE} state_t;
`endif

    localparam logic [7:0] CYC_LAST  = 8'(BIT_CYCLES - 1);
    localparam logic [7:0] BYTE_LAST = 8'(NUM_BYTES - 1);

    state_t      state, state_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  cyc_cnt, cyc_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  byte_cnt, byte_cnt_nxt;
    logic        bit_out_nxt, valid_nxt, req_nxt, busy_nxt, done_nxt;
    logic        bit_end, load_byte, finish_byte;
`ifdef TEXT_SERIALIZER_PARITY_EN
    logic        par_acc, par_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= 8'd0;
            cyc_cnt   <= 8'd0;
            bit_cnt   <= 4'd0;
            byte_cnt  <= 8'd0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            byte_req  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            cyc_cnt   <= cyc_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_cnt  <= byte_cnt_nxt;
            bit_out   <= bit_out_nxt;
            bit_valid <= valid_nxt;
            byte_req  <= req_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

`ifdef TEXT_SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) par_acc <= 1'b0;
        else        par_acc <= par_nxt;
    end
`endif

    // Outputs are computed one cycle ahead so every output leaves a flop.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        cyc_nxt      = cyc_cnt;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        bit_out_nxt  = bit_out;
        valid_nxt    = bit_valid;
        req_nxt      = 1'b0;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        load_byte    = 1'b0;
        finish_byte  = 1'b0;
`ifdef TEXT_SERIALIZER_PARITY_EN
        par_nxt      = par_acc;
`endif
        bit_end      = (cyc_cnt == CYC_LAST);

        case (state)
            IDLE: begin
                bit_out_nxt = 1'b0;
                valid_nxt   = 1'b0;
                busy_nxt    = 1'b0;
                if (start) begin
                    state_nxt    = PRE;
                    shreg_nxt    = PREAMBLE;
                    cyc_nxt      = 8'd0;
                    bit_cnt_nxt  = 4'd0;
                    byte_cnt_nxt = 8'd0;
                    bit_out_nxt  = PREAMBLE[7];
                    valid_nxt    = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            PRE: begin
                if (bit_end) begin
                    cyc_nxt = 8'd0;
                    if (bit_cnt == 4'd7) begin
                        load_byte = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        shreg_nxt   = {shreg[6:0], 1'b0};
                        bit_out_nxt = shreg[6];
                    end
                end else begin
                    cyc_nxt = cyc_cnt + 8'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_nxt = 8'd0;
`ifdef TEXT_SERIALIZER_PARITY_EN
                    par_nxt = par_acc ^ shreg[0];
`endif
                    if (bit_cnt == 4'd7) begin
`ifdef TEXT_SERIALIZER_PARITY_EN
                        state_nxt   = PAR;
                        bit_out_nxt = par_acc ^ shreg[0];
`else
                        finish_byte = 1'b1;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        bit_out_nxt = shreg[1];
                    end
                end else begin
                    cyc_nxt = cyc_cnt + 8'd1;
                end
            end
`ifdef TEXT_SERIALIZER_PARITY_EN
            PAR: begin
                if (bit_end) finish_byte = 1'b1;
                else         cyc_nxt = cyc_cnt + 8'd1;
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (finish_byte) begin
            if (byte_cnt < BYTE_LAST) begin
                byte_cnt_nxt = byte_cnt + 8'd1;
                load_byte    = 1'b1;
            end else begin
                state_nxt    = DONE;
                byte_cnt_nxt = 8'd0;
                cyc_nxt      = 8'd0;
                bit_cnt_nxt  = 4'd0;
                bit_out_nxt  = 1'b0;
                valid_nxt    = 1'b0;
                busy_nxt     = 1'b0;
                done_nxt     = 1'b1;
            end
        end

        // Entering DATA: latch the reader byte and step the reader exactly once.
        if (load_byte) begin
            state_nxt   = DATA;
            shreg_nxt   = byte_in;
            bit_out_nxt = byte_in[0];
            bit_cnt_nxt = 4'd0;
            cyc_nxt     = 8'd0;
            req_nxt     = 1'b1;
`ifdef TEXT_SERIALIZER_PARITY_EN
            par_nxt     = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_text_serializer.sv
// Bench for text_serializer: a 10-byte/4-cycle instance fed by a reader model and a 1-byte/1-cycle instance.
`timescale 1ns/1ps
module tb_text_serializer;
`ifdef TEXT_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int         NB_M = 10;
    localparam int         BC_M = 4;
    localparam logic [7:0] PRE  = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_m = 1'b0, start_s = 1'b0, rewind = 1'b0, use_s = 1'b0;
    logic [7:0] rd_data, rd_addr, byte_s = 8'h00;
    logic [7:0] mem [0:255];
    logic       req_m, bit_m, valid_m, busy_m, done_m;
    logic       req_s, bit_s, valid_s, busy_s, done_s;
    int         checks = 0, errors = 0;
    logic [7:0] exp_bytes[$];

    wire m_req   = use_s ? req_s   : req_m;
    wire m_bit   = use_s ? bit_s   : bit_m;
    wire m_valid = use_s ? valid_s : valid_m;
    wire m_busy  = use_s ? busy_s  : busy_m;
    wire m_done  = use_s ? done_s  : done_m;

    text_serializer #(.NUM_BYTES(NB_M), .BIT_CYCLES(BC_M), .PREAMBLE(PRE)) u_main (
        .clk(clk), .reset(reset), .start(start_m), .byte_in(rd_data),
        .byte_req(req_m), .bit_out(bit_m), .bit_valid(valid_m), .busy(busy_m), .done(done_m));

    text_serializer #(.NUM_BYTES(1), .BIT_CYCLES(1), .PREAMBLE(PRE)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .byte_in(byte_s),
        .byte_req(req_s), .bit_out(bit_s), .bit_valid(valid_s), .busy(busy_s), .done(done_s));

    always #5 clk = ~clk;

    // Reader: address steps on start_read, saturating at its end address; one cycle of read latency.
    always @(posedge clk) begin
        if (!reset || rewind) rd_addr <= 8'd0;
        else if (req_m && rd_addr < 8'(NB_M - 1)) rd_addr <= rd_addr + 8'd1;
        rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        if (use_s) start_s = 1'b1; else start_m = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start_m = 1'b0;
    endtask

    task automatic prep_main();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        exp_bytes = {};
        for (int i = 0; i < NB_M; i++) exp_bytes.push_back(mem[i]);
        @(negedge clk); rewind = 1'b1;
        @(negedge clk); rewind = 1'b0;
        @(negedge clk);
    endtask

    // Starts a frame on the selected instance and checks it against the expected bit list.
    task automatic run_frame(input string tag, input int nb, input int bc, input int mid_start);
        bit exp_bits[$];
        int f, cyc, first_v, last_v, n_valid, bit_err, n_req, req_err, n_done, done_at, busy_err, budget, idx;
        bit par;
        for (int i = 0; i < 8; i++) exp_bits.push_back(PRE[7 - i]);
        foreach (exp_bytes[j]) begin
            par = 1'b0;
            for (int i = 0; i < 8; i++) begin
                exp_bits.push_back(exp_bytes[j][i]);
                par ^= exp_bytes[j][i];
            end
            if (P == 1) exp_bits.push_back(par);
        end
        f = exp_bits.size();
        budget = f * bc + 20;
        first_v = -1; last_v = -1; done_at = -1;
        n_valid = 0; bit_err = 0; n_req = 0; req_err = 0; n_done = 0; busy_err = 0;
        pulse_start();
        cyc = 0;
        while (cyc < budget) begin
            if (m_valid) begin
                if (first_v < 0) first_v = cyc;
                idx = (cyc - first_v) / bc;
                if (idx >= f || m_bit !== exp_bits[idx]) bit_err++;
                n_valid++;
                last_v = cyc;
                if (!m_busy) busy_err++;
            end
            if (m_req) begin
                if (first_v < 0 || cyc - first_v != (8 + n_req * (8 + P)) * bc) req_err++;
                n_req++;
            end
            if (m_done) begin
                n_done++;
                if (done_at < 0) done_at = cyc;
                if (m_busy || m_valid) busy_err++;
            end
            if (done_at >= 0 && cyc >= done_at + 3) break;
            if (cyc == mid_start) begin
                if (use_s) start_s = 1'b1; else start_m = 1'b1;
            end
            @(negedge clk);
            start_s = 1'b0;
            start_m = 1'b0;
            cyc++;
        end
        check({tag, ".first_valid"}, first_v, 0);
        check({tag, ".valid_len"}, n_valid, (8 + nb * (8 + P)) * bc);
        check({tag, ".contiguous"}, last_v - first_v + 1, n_valid);
        check({tag, ".bits"}, bit_err, 0);
        check({tag, ".req_cnt"}, n_req, nb);
        check({tag, ".req_pos"}, req_err, 0);
        check({tag, ".done_cnt"}, n_done, 1);
        check({tag, ".done_at"}, done_at, last_v + 1);
        check({tag, ".busy"}, busy_err, 0);
    endtask

    initial begin
        int idle_err;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        #1 reset = 1'b0;
        idle_err = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({req_m, bit_m, valid_m, busy_m, done_m, req_s, bit_s, valid_s, busy_s, done_s} !== 10'd0) idle_err++;
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({req_m, bit_m, valid_m, busy_m, done_m, req_s, bit_s, valid_s, busy_s, done_s} !== 10'd0) idle_err++;
        end
        check("idle.outputs", idle_err, 0);

        use_s = 1'b1;
        byte_s = 8'h41; exp_bytes = {8'h41};
        run_frame("s41", 1, 1, -1);
        byte_s = 8'h07; exp_bytes = {8'h07};
        run_frame("s07", 1, 1, -1);
        for (int k = 0; k < 3; k++) begin
            byte_s = 8'($urandom_range(0, 255));
            exp_bytes = {byte_s};
            run_frame("srand", 1, 1, -1);
        end

        use_s = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prep_main();
            run_frame("main", NB_M, BC_M, -1);
        end
        prep_main();
        run_frame("main_midstart", NB_M, BC_M, 60);

        prep_main();
        pulse_start();
        repeat ((8 + 3 * (8 + P)) * BC_M + 5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.outputs", int'({req_m, bit_m, valid_m, busy_m, done_m}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        prep_main();
        run_frame("after_rst", NB_M, BC_M, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
